m_dmux8way16_buf: RTL and testbench
===================================

# m_dmux8way16_buf

Registered 1-to-8 demultiplexer for 16-bit words, the write-side counterpart of the 8-way 16-bit selector in the Boolean Logic library. One upstream producer presents a word plus a 3-bit channel select; the block captures it into a one-entry holding register for the selected channel and presents it to that channel's consumer under a valid/ready handshake. It feeds the register-bank and RAM8 write paths, where eight consumers drain independently and may stall.

## Interface
Parameters:
- none; width fixed at 16, channel count fixed at 8.

Ports:
- i_clk  input  1  system clock; all state changes on rising edge.
- i_rst_n  input  1  reset; synchronous, active-low.
- i_in  input  16  upstream data word.
- i_sel  input  3  destination channel: 0 routes to o_a, 1 to o_b, … 7 to o_h.
- i_valid  input  1  upstream word and select are valid this cycle.
- o_ready  output  1  block accepts the upstream word this cycle.
- o_a, o_b, o_c, o_d, o_e, o_f, o_g, o_h  output  16 each  channel data.
- o_valid  output  8  per-channel valid; bit k belongs to channel k (bit 0 = o_a).
- i_ready  input  8  per-channel consumer ready; bit k belongs to channel k.

## Operation
- Each channel k holds one 16-bit data register and one full flag (full[k] drives o_valid[k]).
- o_ready = !full[i_sel] || i_ready[i_sel]. Combinational on i_sel and i_ready, independent of i_valid.
- Accept: i_valid && o_ready. On accept, data[i_sel] <= i_in and full[i_sel] <= 1.
- Drain: full[k] && i_ready[k]. On drain with no accept to channel k, full[k] <= 0.
- Drain and accept on the same channel in the same cycle: the new word replaces the old, full stays 1, no bubble, no loss.
- Accept to channel j while channel k != j drains: both happen independently.
- A full channel with i_ready low holds its data and o_valid stable until drained. An upstream word targeting it stalls (o_ready=0). Other channels are unaffected when i_sel changes.
- i_sel and i_in are ignored when i_valid=0. No state changes without an accept or a drain.
- At most one accept per cycle. Up to eight drains per cycle.

## Timing
- Reset (i_rst_n=0 at a rising edge): all full flags 0, all data registers 16'h0000, hence o_valid=8'h00 and o_a..o_h = 16'h0000. o_ready reads 1 during and after reset.
- Reset asserted mid-transfer discards held words. No drain is reported for them.
- Latency: a word accepted at edge N appears on its channel with o_valid high after edge N, i.e. in cycle N+1.
- Throughput: one word per cycle sustained while the targeted consumer holds i_ready high.
- o_valid and channel data are register outputs, with no combinational path from i_in or i_valid.

## Configuration
- Macro: DMUX8WAY16_ZERO_IDLE_EN.
- Defined: each channel data output is gated to 16'h0000 whenever its o_valid bit is 0. Idle channels read zero, matching the combinational demux convention of zero on unselected outputs.
- Undefined: channel data outputs show the data register directly and hold the last accepted word after drain. This costs no gating logic.
- Handshake, full flags and latency are identical in both builds.

## Test plan
- Reset then single write: i_in=16'hBEEF, i_sel=3, i_valid=1 for one cycle, all i_ready=0 -> next cycle o_d=16'hBEEF, o_valid=8'h08, all other channels 0.
- Backpressure: channel 3 full, i_ready[3]=0, new word 16'h1234 to sel=3 -> o_ready=0, o_d stays 16'hBEEF. Raise i_ready[3] -> same cycle o_ready=1, accepted, next cycle o_d=16'h1234 with o_valid[3] still 1.
- Round-robin burst: sel 0..7 with words 16'h0000..16'h0007 on consecutive cycles, all i_ready=0 -> o_ready=1 throughout, o_valid=8'hFF after 8 cycles, each channel k holds k.
- Parallel drain plus accept: all full, i_ready=8'hFF for one cycle with write 16'hAAAA to sel=5 -> next cycle o_valid=8'h20, o_f=16'hAAAA.
- Reset mid-operation: o_valid=8'hFF, assert i_rst_n=0 for one edge -> o_valid=8'h00, all data 16'h0000, o_ready=1.
- Idle data, built both ways: after draining channel 3 of 16'hBEEF, o_d=16'h0000 with DMUX8WAY16_ZERO_IDLE_EN defined, o_d=16'hBEEF without it.

Source files
------------

// File: rtl/m_dmux8way16_buf.sv
`default_nettype none
// ============================================================================
// Module   : m_dmux8way16_buf
// Purpose  : Registered 1-to-8 demultiplexer for 16-bit words. One upstream
//            producer writes a word into a one-entry holding register for
//            the channel named by i_sel. Each of the eight consumers drains
//            its own channel independently under a valid/ready handshake.
//
// Ports    : i_clk            system clock, rising edge
//            i_rst_n          synchronous active-low reset
//            i_in[15:0]       upstream data word
//            i_sel[2:0]       destination channel (0 -> o_a ... 7 -> o_h)
//            i_valid          upstream word/select valid
//            o_ready          upstream word accepted this cycle when valid
//            o_a..o_h[15:0]   channel data (register outputs)
//            o_valid[7:0]     per-channel valid, bit k = channel k
//            i_ready[7:0]     per-channel consumer ready, bit k = channel k
//
// Config   : DMUX8WAY16_ZERO_IDLE_EN - when defined, each channel data output
//            reads 16'h0000 while its o_valid bit is low. When undefined the
//            data register is shown directly and keeps the last accepted word.
//
// Revision : 1.0 - initial release
// ============================================================================

module m_dmux8way16_buf (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_in,
    input  logic [2:0]  i_sel,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [15:0] o_a,
    output logic [15:0] o_b,
    output logic [15:0] o_c,
    output logic [15:0] o_d,
    output logic [15:0] o_e,
    output logic [15:0] o_f,
    output logic [15:0] o_g,
    output logic [15:0] o_h,
    output logic [7:0]  o_valid,
    input  logic [7:0]  i_ready
);

    localparam int c_WIDTH = 16;
    localparam int c_CHANS = 8;

    logic [c_CHANS-1:0] r_full;
    logic [c_WIDTH-1:0] r_data [c_CHANS];
    logic [c_WIDTH-1:0] w_dout [c_CHANS];
    logic               w_accept;

    // A full channel whose consumer is ready this cycle frees its slot at the
    // same edge, so the producer may overwrite it without a bubble. Reset
    // forces ready high so the upstream never sees a stall while the holding
    // registers are being cleared.
    assign o_ready  = !i_rst_n || !r_full[i_sel] || i_ready[i_sel];
    assign w_accept = i_valid && o_ready;

    generate
        for (genvar k = 0; k < c_CHANS; k++) begin : g_chan
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_full[k] <= 1'b0;
                    r_data[k] <= '0;
                end else if (w_accept && (i_sel == 3'(k))) begin
                    // Accept wins over a simultaneous drain: new word, still full.
                    r_full[k] <= 1'b1;
                    r_data[k] <= i_in;
                end else if (r_full[k] && i_ready[k]) begin
                    r_full[k] <= 1'b0;
                end
            end

`ifdef DMUX8WAY16_ZERO_IDLE_EN
            assign w_dout[k] = r_full[k] ? r_data[k] : '0;
`else
            assign w_dout[k] = r_data[k];
`endif
        end
    endgenerate

    assign o_valid = r_full;
    assign o_a     = w_dout[0];
    assign o_b     = w_dout[1];
    assign o_c     = w_dout[2];
    assign o_d     = w_dout[3];
    assign o_e     = w_dout[4];
    assign o_f     = w_dout[5];
    assign o_g     = w_dout[6];
    assign o_h     = w_dout[7];

endmodule

`default_nettype wire

// File: tb/tb_m_dmux8way16_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_dmux8way16_buf
// Purpose  : Self-checking bench for m_dmux8way16_buf. A driver issues
//            directed and random transfers and pushes each accepted word into
//            a per-channel expected queue; a monitor on the falling edge
//            compares handshake, valid and data against those queues and pops
//            an entry whenever a consumer drains its channel.
// Revision : 1.0 - initial release
// ============================================================================

module tb_m_dmux8way16_buf;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic [15:0] i_in;
    logic [2:0]  i_sel;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] o_a, o_b, o_c, o_d, o_e, o_f, o_g, o_h;
    logic [7:0]  o_valid;
    logic [7:0]  i_ready;

    int n_checks = 0;
    int n_errors = 0;
    logic mon_en = 1'b0;

    // Reference model: each channel is a FIFO of capacity one; last[] is the
    // most recently accepted word per channel (what an idle channel shows
    // when outputs are not zero-gated).
    logic [15:0] exp_q [0:7][$];
    logic [15:0] last  [0:7];
    logic [15:0] dout  [0:7];

    always #5 clk = ~clk;

    m_dmux8way16_buf dut (
        .i_clk   (clk),
        .i_rst_n (i_rst_n),
        .i_in    (i_in),
        .i_sel   (i_sel),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_a     (o_a),
        .o_b     (o_b),
        .o_c     (o_c),
        .o_d     (o_d),
        .o_e     (o_e),
        .o_f     (o_f),
        .o_g     (o_g),
        .o_h     (o_h),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    always_comb begin
        dout[0] = o_a; dout[1] = o_b; dout[2] = o_c; dout[3] = o_d;
        dout[4] = o_e; dout[5] = o_f; dout[6] = o_g; dout[7] = o_h;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: sample mid-cycle, then retire words the consumers take at the
    // coming rising edge.
    initial begin
        logic        exp_rdy;
        logic [15:0] exp_d;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_rdy = !i_rst_n || (exp_q[i_sel].size() == 0) || i_ready[i_sel];
                check("o_ready", {15'd0, o_ready}, {15'd0, exp_rdy});
                for (int k = 0; k < 8; k++) begin
                    check($sformatf("o_valid[%0d]", k), {15'd0, o_valid[k]},
                          {15'd0, exp_q[k].size() != 0});
                    if (exp_q[k].size() != 0) exp_d = exp_q[k][0];
`ifdef DMUX8WAY16_ZERO_IDLE_EN
                    else exp_d = 16'h0000;
`else
                    else exp_d = last[k];
`endif
                    check($sformatf("data[%0d]", k), dout[k], exp_d);
                    if (exp_q[k].size() != 0 && i_ready[k]) void'(exp_q[k].pop_front());
                end
            end
        end
    end

    // One clock of stimulus. The accept decision is made from the model state
    // before the edge; the monitor has already retired drains by the time the
    // edge arrives, so the push lands in a free slot.
    task automatic cycle(input logic v, input logic [2:0] s, input logic [15:0] d,
                         input logic [7:0] r, input logic rn);
        logic acc;
        i_valid = v;
        i_sel   = s;
        i_in    = d;
        i_ready = r;
        i_rst_n = rn;
        acc = rn && v && ((exp_q[s].size() == 0) || r[s]);
        @(posedge clk);
        if (!rn) begin
            for (int k = 0; k < 8; k++) begin
                exp_q[k].delete();
                last[k] = 16'h0000;
            end
        end else if (acc) begin
            exp_q[s].push_back(d);
            last[s] = d;
        end
        #1;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) last[k] = 16'h0000;
        i_valid = 1'b0; i_sel = 3'd0; i_in = 16'h0; i_ready = 8'h00; i_rst_n = 1'b0;
        @(posedge clk); #1;
        cycle(1'b0, 3'd0, 16'h0, 8'h00, 1'b0);
        mon_en = 1'b1;

        // Single write, then backpressure on the same channel
        cycle(1'b1, 3'd3, 16'hBEEF, 8'h00, 1'b1);
        cycle(1'b1, 3'd3, 16'h1234, 8'h00, 1'b1);
        cycle(1'b1, 3'd3, 16'h1234, 8'h08, 1'b1);
        cycle(1'b0, 3'd0, 16'h0,    8'h00, 1'b1);
        // Drain channel 3 and observe the idle value
        cycle(1'b0, 3'd0, 16'h0,    8'h08, 1'b1);
        cycle(1'b0, 3'd0, 16'h0,    8'h00, 1'b1);
        cycle(1'b0, 3'd0, 16'h0,    8'h00, 1'b1);

        // Round-robin burst, then parallel drain with accept to channel 5
        for (int k = 0; k < 8; k++) cycle(1'b1, 3'(k), 16'(k), 8'h00, 1'b1);
        cycle(1'b1, 3'd5, 16'hAAAA, 8'hFF, 1'b1);
        cycle(1'b0, 3'd0, 16'h0,    8'h00, 1'b1);

        // Refill everything, then reset mid-operation
        for (int k = 0; k < 8; k++) cycle(1'b1, 3'(k), 16'hC000 + 16'(k), 8'h00, 1'b1);
        cycle(1'b1, 3'd2, 16'h5555, 8'hFF, 1'b0);
        cycle(1'b0, 3'd0, 16'h0,    8'h00, 1'b1);

        // Random traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] r;
            r = 8'($urandom) & 8'($urandom);
            cycle(($urandom_range(0, 3) != 0), 3'($urandom), 16'($urandom), r,
                  ($urandom_range(0, 199) != 0));
        end

        cycle(1'b0, 3'd0, 16'h0, 8'h00, 1'b1);
        cycle(1'b0, 3'd0, 16'h0, 8'hFF, 1'b1);
        cycle(1'b0, 3'd0, 16'h0, 8'h00, 1'b1);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
